// File: rtl/u_cla8_serial_add.sv
// u_cla8_serial_add: byte-serial adder for multi-byte operands.
// Operands arrive least-significant byte first. Each accepted beat goes through
// one 8-bit carry-lookahead stage. The carry between bytes is kept in carry_q.
// The result goes into a 1-entry ready/valid output register.
module u_cla8_serial_add #(
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic             in_first,
    input  logic             in_last,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_sum,
    output logic             out_last,
    output logic             out_cout,
    output logic [IDX_W-1:0] out_idx,
    output logic             proto_err
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

    // 8-bit carry-lookahead stage. Each carry is expanded from generate and
    // propagate terms and the carry-in, so no carry ripples through the sum bits.
    function automatic logic [8:0] cla8(input logic [7:0] a, input logic [7:0] b,
                                        input logic ci);
        logic [7:0] g;
        logic [7:0] p;
        logic [8:0] c;
        logic       pp;
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < 8; i++) begin
            pp       = p[i];
            c[i+1]   = g[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (pp & g[j]);
                pp     = pp & p[j];
            end
            c[i+1] = c[i+1] | (pp & ci);
        end
        return {c[8], p ^ c[7:0]};
    endfunction

    state_t           state_q, state_d;
    logic             carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             err_q, err_d;
    logic             ov_q, ov_d;
    logic [7:0]       sum_q, sum_d;
    logic             last_q, last_d;
    logic             cout_q, cout_d;
    logic [IDX_W-1:0] oidx_q, oidx_d;

    logic             expect_first;
    logic             accept;
    logic             restart;
    logic             c_sel;
    logic [IDX_W-1:0] idx_cur;
    logic             c_next;
    logic [7:0]       s;

    assign in_ready = !ov_q || out_ready;
    assign accept   = in_valid && in_ready;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next state: a last beat always closes the frame, any other beat opens or continues one
    always_comb begin
        state_d = state_q;
        if (accept) state_d = in_last ? IDLE : BUSY;
    end

    // FSM outputs: IDLE means the next beat is treated as a first beat
    always_comb begin
        expect_first = (state_q == IDLE);
    end

    // Beat decode: a first beat or any beat seen while IDLE restarts from in_cin and index 0
    always_comb begin
        restart = in_first || expect_first;
        c_sel   = restart ? in_cin : carry_q;
        idx_cur = restart ? '0 : idx_q;
    end

    assign {c_next, s} = cla8(in_a, in_b, c_sel);

    // Next values for the frame context and the output register
    always_comb begin
        carry_d = carry_q;
        idx_d   = idx_q;
        err_d   = err_q;
        ov_d    = ov_q;
        sum_d   = sum_q;
        last_d  = last_q;
        cout_d  = cout_q;
        oidx_d  = oidx_q;
        if (accept) begin
            carry_d = in_last ? 1'b0 : c_next;
            idx_d   = in_last ? '0 : idx_cur + IDX_ONE;
            err_d   = err_q | (in_first && !expect_first) | (!in_first && expect_first);
            ov_d    = 1'b1;
            sum_d   = s;
            last_d  = in_last;
            cout_d  = in_last & c_next;
            oidx_d  = idx_cur;
        end else if (out_ready) begin
            ov_d    = 1'b0;
        end
    end

    // Frame context and output register; reset drops any in-flight frame or held result
    always_ff @(posedge clk) begin
        if (rst) begin
            carry_q <= 1'b0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            ov_q    <= 1'b0;
            sum_q   <= '0;
            last_q  <= 1'b0;
            cout_q  <= 1'b0;
            oidx_q  <= '0;
        end else begin
            carry_q <= carry_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            ov_q    <= ov_d;
            sum_q   <= sum_d;
            last_q  <= last_d;
            cout_q  <= cout_d;
            oidx_q  <= oidx_d;
        end
    end

    assign out_valid = ov_q;
    assign out_sum   = sum_q;
    assign out_last  = last_q;
    assign out_cout  = cout_q;
    assign out_idx   = oidx_q;
    assign proto_err = err_q;

endmodule

// File: tb/tb_u_cla8_serial_add.sv
// Testbench for u_cla8_serial_add. The reference model treats each frame as
// whole integers: byte k of the result is byte k of (A + B + cin), computed
// from the operand bytes received so far.
module tb_u_cla8_serial_add;

    typedef struct packed {
        logic [7:0] sum;
        logic       last;
        logic       cout;
        logic [3:0] idx;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       in_first;
    logic       in_last;
    logic       in_cin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_sum;
    logic       out_last;
    logic       out_cout;
    logic [3:0] out_idx;
    logic       proto_err;

    int errors = 0;
    int checks = 0;

    beat_t exp_q[$];
    beat_t obs_q[$];

    // Frame-level reference model state
    bit              m_idle = 1'b1;
    bit              m_err  = 1'b0;
    longint unsigned m_A, m_B, m_tot;
    bit              m_cin;
    int              m_k;
    bit              rand_ready = 1'b0;

    u_cla8_serial_add #(.IDX_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_first(in_first), .in_last(in_last),
        .in_cin(in_cin), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_last(out_last), .out_cout(out_cout),
        .out_idx(out_idx), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Model: one accepted input beat
    task automatic model_accept(input logic [7:0] a, input logic [7:0] b,
                                input logic f, input logic l, input logic ci);
        beat_t e;
        if (f && !m_idle) m_err = 1'b1;
        if (!f && m_idle) m_err = 1'b1;
        if (f || m_idle) begin
            m_A = 64'(a); m_B = 64'(b); m_cin = ci; m_k = 0;
        end else begin
            m_k++;
            m_A = m_A | (64'(a) << (8 * m_k));
            m_B = m_B | (64'(b) << (8 * m_k));
        end
        m_tot  = m_A + m_B + 64'(m_cin);
        e.sum  = 8'((m_tot >> (8 * m_k)) & 64'hFF);
        e.last = l;
        e.cout = l ? 1'((m_tot >> (8 * (m_k + 1))) & 64'h1) : 1'b0;
        e.idx  = 4'(m_k % 16);
        exp_q.push_back(e);
        m_idle = l;
    endtask

    // One clock cycle: drive, check the registered state, score any output
    // transfer, then advance past the next rising edge.
    task automatic cyc(input logic iv, input logic [7:0] a, input logic [7:0] b,
                       input logic f, input logic l, input logic ci, output logic acc);
        beat_t e;
        beat_t o;
        in_valid = iv; in_a = a; in_b = b; in_first = f; in_last = l; in_cin = ci;
        if (rand_ready) out_ready = ($urandom_range(3) != 0);
        #1;
        check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        check("proto_err", 32'(proto_err), 32'(m_err));
        if (out_valid === 1'b1 && out_ready) begin
            o = '{sum: out_sum, last: out_last, cout: out_cout, idx: out_idx};
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 32'(1), 32'(0));
            end else begin
                e = exp_q.pop_front();
                check("out_sum",  32'(o.sum),  32'(e.sum));
                check("out_last", 32'(o.last), 32'(e.last));
                check("out_cout", 32'(o.cout), 32'(e.cout));
                check("out_idx",  32'(o.idx),  32'(e.idx));
            end
            obs_q.push_back(o);
        end
        acc = iv && (in_ready === 1'b1);
        if (acc) model_accept(a, b, f, l, ci);
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b,
                        input logic f, input logic l, input logic ci);
        logic acc;
        int n;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 200) begin
            cyc(1'b1, a, b, f, l, ci, acc);
            n++;
        end
        if (!acc) check("send_timeout", 32'(0), 32'(1));
    endtask

    task automatic idle_cycles(input int n);
        logic acc;
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, acc);
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready",  32'(in_ready),  32'(1));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_proto_err", 32'(proto_err), 32'(0));
        check("rst_out_sum",   32'(out_sum),   32'(0));
        check("rst_out_last",  32'(out_last),  32'(0));
        check("rst_out_cout",  32'(out_cout),  32'(0));
        check("rst_out_idx",   32'(out_idx),   32'(0));
        rst = 1'b0;
        exp_q.delete();
        m_idle = 1'b1;
        m_err  = 1'b0;
    endtask

    initial begin
        logic acc;
        logic [7:0] held;
        int len;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_first = 1'b0; in_last = 1'b0; in_cin = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        do_reset();

        // Carry chain: 0x01FF + 0x0001
        obs_q.delete();
        send(8'hFF, 8'h01, 1'b1, 1'b0, 1'b0);
        send(8'h01, 8'h00, 1'b0, 1'b1, 1'b0);
        idle_cycles(2);
        check("chain_n", 32'(obs_q.size()), 32'(2));
        if (obs_q.size() == 2) begin
            check("chain_s0",  32'(obs_q[0].sum),  32'h00);
            check("chain_i0",  32'(obs_q[0].idx),  32'(0));
            check("chain_s1",  32'(obs_q[1].sum),  32'h02);
            check("chain_i1",  32'(obs_q[1].idx),  32'(1));
            check("chain_co",  32'(obs_q[1].cout), 32'(0));
        end

        // Overflow: 0xFFFF + 0x0001
        obs_q.delete();
        send(8'hFF, 8'h01, 1'b1, 1'b0, 1'b0);
        send(8'hFF, 8'h00, 1'b0, 1'b1, 1'b0);
        idle_cycles(2);
        if (obs_q.size() == 2) begin
            check("ovf_s1",   32'(obs_q[1].sum),  32'h00);
            check("ovf_last", 32'(obs_q[1].last), 32'(1));
            check("ovf_cout", 32'(obs_q[1].cout), 32'(1));
        end else check("ovf_n", 32'(obs_q.size()), 32'(2));

        // Single byte with carry-in; a following first beat must not flag an error
        obs_q.delete();
        send(8'h7F, 8'h80, 1'b1, 1'b1, 1'b1);
        send(8'h01, 8'h01, 1'b1, 1'b1, 1'b0);
        idle_cycles(2);
        if (obs_q.size() == 2) begin
            check("single_sum",  32'(obs_q[0].sum),  32'h00);
            check("single_cout", 32'(obs_q[0].cout), 32'(1));
        end else check("single_n", 32'(obs_q.size()), 32'(2));
        check("single_noerr", 32'(proto_err), 32'(0));

        // Backpressure during a 4-byte frame
        obs_q.delete();
        send(8'h11, 8'hF0, 1'b1, 1'b0, 1'b0);
        out_ready = 1'b0;
        held = out_sum;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; #1;
            check("bp_in_ready", 32'(in_ready), 32'(0));
            check("bp_hold_sum", 32'(out_sum),  32'(held));
            cyc(1'b1, 8'h22, 8'hEE, 1'b0, 1'b0, 1'b0, acc);
            check("bp_no_accept", 32'(acc), 32'(0));
        end
        out_ready = 1'b1;
        send(8'h22, 8'hEE, 1'b0, 1'b0, 1'b0);
        send(8'h33, 8'hCC, 1'b0, 1'b0, 1'b0);
        send(8'h44, 8'hBB, 1'b0, 1'b1, 1'b0);
        idle_cycles(2);
        check("bp_n", 32'(obs_q.size()), 32'(4));

        // Framing error: first beat in the middle of a frame
        obs_q.delete();
        send(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1);
        send(8'h10, 8'h20, 1'b1, 1'b0, 1'b0);
        send(8'h01, 8'h02, 1'b0, 1'b1, 1'b0);
        idle_cycles(2);
        check("ferr_flag", 32'(proto_err), 32'(1));
        if (obs_q.size() == 3) begin
            check("ferr_s1", 32'(obs_q[1].sum), 32'h30);
            check("ferr_i1", 32'(obs_q[1].idx), 32'(0));
            check("ferr_s2", 32'(obs_q[2].sum), 32'h03);
        end else check("ferr_n", 32'(obs_q.size()), 32'(3));

        // Reset mid-frame
        obs_q.delete();
        send(8'h01, 8'h01, 1'b1, 1'b0, 1'b0);
        do_reset();
        send(8'h05, 8'h03, 1'b1, 1'b1, 1'b0);
        idle_cycles(2);
        if (obs_q.size() >= 1)
            check("rst_new_sum", 32'(obs_q[obs_q.size()-1].sum), 32'h08);
        else check("rst_new_n", 32'(obs_q.size()), 32'(1));

        // Randomized well-formed frames with random backpressure and gaps
        rand_ready = 1'b1;
        for (int fr = 0; fr < 40; fr++) begin
            len = $urandom_range(6, 1);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(4) == 0) idle_cycles(1);
                send(8'($urandom), 8'($urandom), k == 0, k == len - 1, 1'($urandom));
            end
        end
        rand_ready = 1'b0;
        out_ready = 1'b1;
        idle_cycles(3);
        check("rand_drained", 32'(exp_q.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/u_cla8_serial_add.md
U_CLA8_SERIAL_ADD -- requirements
Module: u_cla8_serial_add

Interface
REQ-001 Parameter IDX_W, default 4: width of the byte-index output.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  upstream beat valid.
REQ-005 in_ready  output  1  block can accept a beat this cycle.
REQ-006 in_a  input  8  operand A byte, least-significant byte first.
REQ-007 in_b  input  8  operand B byte.
REQ-008 in_first  input  1  beat is the least-significant byte of a frame.
REQ-009 in_last  input  1  beat is the most-significant byte of a frame.
REQ-010 in_cin  input  1  frame carry-in, sampled only on a first beat.
REQ-011 out_valid  output  1  result beat valid.
REQ-012 out_ready  input  1  downstream accepts the result beat.
REQ-013 out_sum  output  8  sum byte.
REQ-014 out_last  output  1  result beat closes its frame.
REQ-015 out_cout  output  1  frame carry-out; meaningful only when out_last=1, else 0.
REQ-016 out_idx  output  IDX_W  byte index within the frame, 0 on the first beat.
REQ-017 proto_err  output  1  sticky framing-error flag.

Function
REQ-018 A beat transfers on the input when in_valid && in_ready, and on the output when out_valid && out_ready.
REQ-019 Per accepted beat, the block SHALL compute {c_next, s} = in_a + in_b + c, with c = in_cin if in_first, else carry_q; the result is 9 bits and unsigned.
REQ-020 The block SHALL compute c and s with the team's 8-bit carry-lookahead adder stage, and SHALL NOT add a second adder.
REQ-021 The output is a 1-entry register; latency from an accepted input beat to out_valid SHALL be exactly 1 cycle.
REQ-022 in_ready SHALL equal !out_valid || out_ready; back-to-back throughput is 1 beat/cycle, and in_ready does not depend combinationally on in_valid.
REQ-023 While out_valid=1 && out_ready=0, out_sum/out_last/out_cout/out_idx SHALL hold stable.
REQ-024 FSM states: IDLE (expecting a first beat) and BUSY (mid-frame).
- IDLE to BUSY on an accepted beat with in_last=0.
- BUSY to IDLE on an accepted beat with in_last=1.
- IDLE stays IDLE on a single-byte beat (first and last both 1).
REQ-025 carry_q SHALL load c_next on every accepted non-last beat and clear to 0 on an accepted last beat.
REQ-026 The index counter SHALL read 0 on a first beat and increment per accepted beat; it wraps modulo 2^IDX_W with no error.
REQ-027 An accepted in_first=1 beat while BUSY SHALL abandon the open frame, restart with in_cin and idx 0, and set proto_err.
REQ-028 An accepted in_first=0 beat while IDLE SHALL be processed as a first beat using in_cin and idx 0, and SHALL set proto_err.
REQ-029 out_cout = c_next of the last beat; out_last mirrors the accepted in_last.
REQ-030 Beats with in_valid=0 SHALL NOT change carry_q, idx, the FSM state or proto_err.

Reset
REQ-031 When rst=1 at a clock edge, the block SHALL apply all of the following.
- FSM goes to IDLE.
- carry_q=0, idx=0, proto_err=0.
- out_valid=0, out_sum=0, out_last=0, out_cout=0, out_idx=0.
REQ-032 Reset has priority over a simultaneous transfer; an in-flight frame or held output is discarded.
REQ-033 While rst=1, in_ready SHALL be 1 as a consequence of out_valid=0; no beat is accepted.

Verification
REQ-034 The bench SHALL cover each of the following directed scenarios.
- Carry chain: 2-byte frame A=0x01FF, B=0x0001, cin=0, out_ready=1 -> sum bytes 0x00 then 0x02, cout=0, idx 0 then 1.
- Overflow: 2-byte frame 0xFFFF+0x0001, cin=0 -> bytes 0x00, 0x00, out_last=1, out_cout=1.
- Single byte with carry-in: first=last=1, 0x7F+0x80, cin=1 -> out_sum=0x00, out_cout=1, state remains IDLE.
- Backpressure: out_ready=0 for 3 cycles during a 4-byte frame -> in_ready=0 and the output holds; after release all 4 bytes arrive in order with correct values.
- Framing error: in_first=1 mid-frame -> proto_err=1, new frame sums correctly from idx 0, carry restarts from in_cin.
- Reset mid-frame: rst after byte 1 of 3 -> out_valid=0 and proto_err=0 next cycle; a new frame 0x05+0x03 gives 0x08.
